// File: rtl/byte_data_memory.sv
// byte_data_memory
//   Byte-addressed RV32 data memory for the load/store unit. Handles SB/SH/SW
//   and LB/LH/LW/LBU/LHU with byte-lane placement, sign/zero extension, and
//   misalignment, illegal-width and range error reporting. After reset it
//   zero-fills the array before it accepts any request.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_CLEAR | writing zero to word r_clear_idx each cycle, req_ready = 0
//   ST_IDLE  | accepting one request per cycle, req_ready = 1
//
// Ports
//   clk        in   1   clock, all state on rising edge
//   reset      in   1   asynchronous active-high reset
//   req_valid  in   1   request present
//   req_ready  out  1   request accepted when req_valid && req_ready
//   req_write  in   1   1 = store, 0 = load
//   req_width  in   3   RV32 funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_addr   in   32  byte address
//   req_wdata  in   32  store data, right-aligned
//   rsp_valid  out  1   one-cycle pulse, response to previous-cycle accept
//   rsp_rdata  out  32  extended load data; 0 for stores and errors
//   rsp_error  out  1   misaligned, illegal width or out of range
module byte_data_memory #(
    parameter int DEPTH_WORDS    = 1024,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_width,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int            AW       = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_clear_idx;
    logic [AW-1:0] w_clear_idx_next;

    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          r_rsp_valid;
    logic [31:0]   r_rsp_rdata;
    logic          r_rsp_error;

    logic          w_accept;
    logic [AW-1:0] w_idx;
    logic          w_err;
    logic [3:0]    w_be;
    logic [31:0]   w_lane_data;
    logic [31:0]   w_rd_word;
    logic [31:0]   w_shifted;
    logic [31:0]   w_load;
    logic          w_clear_we;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= RESET_STATE;
            r_clear_idx <= '0;
        end else begin
            r_state     <= w_state_next;
            r_clear_idx <= w_clear_idx_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_clear_idx_next = r_clear_idx;
        case (r_state)
            ST_CLEAR: begin
                w_clear_idx_next = r_clear_idx + IDX_ONE;
                if (r_clear_idx == LAST_IDX)
                    w_state_next = ST_IDLE;
            end
            default: ;
        endcase
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign w_accept   = req_valid && req_ready;
    assign w_clear_we = (r_state == ST_CLEAR) && !reset;
    assign w_idx      = req_addr[AW+1:2];

    // ---------------- request decode ----------------
    always_comb begin
        w_err       = 1'b0;
        w_be        = 4'b0000;
        w_lane_data = req_wdata;
        case (req_width)
            3'b000: begin
                w_be        = 4'b0001 << req_addr[1:0];
                w_lane_data = {4{req_wdata[7:0]}};
            end
            3'b001: begin
                w_err       = req_addr[0];
                w_be        = req_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{req_wdata[15:0]}};
            end
            3'b010: begin
                w_err = (req_addr[1:0] != 2'b00);
                w_be  = 4'b1111;
            end
            3'b100:  w_err = req_write;
            3'b101:  w_err = req_write || req_addr[0];
            default: w_err = 1'b1;
        endcase
        // Any address bit above the index field means word index >= DEPTH_WORDS.
        if (req_addr[31:AW+2] != '0)
            w_err = 1'b1;
    end

    // Loads see the array as it stands before this edge, so a store accepted on
    // the previous edge is already visible.
    assign w_rd_word = r_mem[w_idx];
    assign w_shifted = w_rd_word >> {req_addr[1:0], 3'b000};

    always_comb begin
        w_load = w_rd_word;
        case (req_width)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load = {24'h0, w_shifted[7:0]};
            3'b101:  w_load = {16'h0, w_shifted[15:0]};
            default: w_load = w_rd_word;
        endcase
    end

    // ---------------- array ----------------
    always_ff @(posedge clk) begin
        if (w_clear_we) begin
            r_mem[r_clear_idx] <= 32'h0;
        end else if (w_accept && req_write && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i])
                    r_mem[w_idx][8*i +: 8] <= w_lane_data[8*i +: 8];
            end
        end
    end

    // ---------------- response ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_error <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_rsp_error <= w_err;
                r_rsp_rdata <= (w_err || req_write) ? 32'h0 : w_load;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;

endmodule

// File: tb/tb_byte_data_memory.sv
module tb_byte_data_memory;

    localparam int DEPTH = 64;
    localparam int BYTES = DEPTH * 4;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_width;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int checks = 0;
    int errors = 0;

    byte_data_memory #(.DEPTH_WORDS(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_width (req_width),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model (byte array) ----------------
    logic [7:0]  m_mem [BYTES];
    int          m_edges;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_err_q;

    function automatic logic m_error(input logic w, input logic [2:0] wd, input logic [31:0] a);
        logic e;
        case (wd)
            3'b000:  e = 1'b0;
            3'b001:  e = a[0];
            3'b010:  e = (a[1:0] != 2'b00);
            3'b100:  e = w;
            3'b101:  e = w || a[0];
            default: e = 1'b1;
        endcase
        if (a >= 32'(BYTES)) e = 1'b1;
        return e;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] wd, input logic [31:0] a);
        int b;
        logic [7:0]  by;
        logic [15:0] hw;
        b  = int'(a[7:0]);
        by = m_mem[b];
        hw = {m_mem[(b+1) % BYTES], m_mem[b]};
        case (wd)
            3'b000:  return {{24{by[7]}}, by};
            3'b100:  return {24'h0, by};
            3'b001:  return {{16{hw[15]}}, hw};
            3'b101:  return {16'h0, hw};
            default: return {m_mem[(b+3) % BYTES], m_mem[(b+2) % BYTES], hw};
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_edges <= 0;
            m_valid <= 1'b0;
            m_data  <= 32'h0;
            m_err_q <= 1'b0;
            for (int i = 0; i < BYTES; i++) m_mem[i] <= 8'h0;
        end else begin
            if (m_edges < DEPTH) m_edges <= m_edges + 1;
            m_valid <= 1'b0;
            if (req_valid && m_edges >= DEPTH) begin
                m_valid <= 1'b1;
                m_err_q <= m_error(req_write, req_width, req_addr);
                m_data  <= (m_error(req_write, req_width, req_addr) || req_write)
                           ? 32'h0 : m_read(req_width, req_addr);
                if (req_write && !m_error(req_write, req_width, req_addr)) begin
                    m_mem[int'(req_addr[7:0])] <= req_wdata[7:0];
                    if (req_width == 3'b001 || req_width == 3'b010)
                        m_mem[int'(req_addr[7:0]) + 1] <= req_wdata[15:8];
                    if (req_width == 3'b010) begin
                        m_mem[int'(req_addr[7:0]) + 2] <= req_wdata[23:16];
                        m_mem[int'(req_addr[7:0]) + 3] <= req_wdata[31:24];
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        checks++;
        if (req_ready !== (m_edges >= DEPTH)) begin
            errors++;
            $display("FAIL ready: got %b expected %b t=%0t", req_ready, (m_edges >= DEPTH), $time);
        end
        checks++;
        if (rsp_valid !== m_valid) begin
            errors++;
            $display("FAIL rsp_valid: got %b expected %b t=%0t", rsp_valid, m_valid, $time);
        end
        if (m_valid) begin
            checks++;
            if (rsp_rdata !== m_data || rsp_error !== m_err_q) begin
                errors++;
                $display("FAIL rsp_model: got %h/%b expected %h/%b t=%0t",
                         rsp_rdata, rsp_error, m_data, m_err_q, $time);
            end
        end
    end

    // ---------------- directed helpers ----------------
    // Called #1 after a rising edge; leaves time at #1 after the accept edge.
    task automatic xfer(input logic w, input logic [2:0] wd, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] ed, input logic ee,
                        input string nm);
        req_valid = 1'b1;
        req_write = w;
        req_width = wd;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== ed || rsp_error !== ee) begin
            errors++;
            $display("FAIL %s: got v=%b d=%h e=%b expected v=1 d=%h e=%b",
                     nm, rsp_valid, rsp_rdata, rsp_error, ed, ee);
        end
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL %s: clear cycles got %0d expected %0d", nm, n, DEPTH);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_width = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got r=%b v=%b d=%h e=%b expected 0/0/0/0",
                     req_ready, rsp_valid, rsp_rdata, rsp_error);
        end
        reset = 1'b0;
        wait_ready("clear_len");

        // zero-filled after clear
        xfer(0, 3'b010, 32'h3C, 0, 32'h00000000, 0, "lw_clear_3c");
        xfer(0, 3'b010, 32'hFC, 0, 32'h00000000, 0, "lw_clear_last");

        // byte lanes
        xfer(1, 3'b010, 32'h10, 32'h11223344, 32'h0, 0, "sw_10");
        xfer(1, 3'b000, 32'h13, 32'h000000AB, 32'h0, 0, "sb_13");
        xfer(0, 3'b010, 32'h10, 0, 32'hAB223344, 0, "lw_10");
        xfer(0, 3'b000, 32'h13, 0, 32'hFFFFFFAB, 0, "lb_13");
        xfer(0, 3'b100, 32'h13, 0, 32'h000000AB, 0, "lbu_13");
        xfer(0, 3'b000, 32'h11, 0, 32'h00000033, 0, "lb_11");
        xfer(0, 3'b001, 32'h12, 0, 32'hFFFFAB22, 0, "lh_12");
        xfer(0, 3'b101, 32'h10, 0, 32'h00003344, 0, "lhu_10");

        // halves
        xfer(1, 3'b001, 32'h22, 32'h00008001, 32'h0, 0, "sh_22");
        xfer(0, 3'b001, 32'h22, 0, 32'hFFFF8001, 0, "lh_22");
        xfer(0, 3'b101, 32'h22, 0, 32'h00008001, 0, "lhu_22");
        xfer(0, 3'b010, 32'h20, 0, 32'h80010000, 0, "lw_20");

        // errors leave memory untouched
        xfer(1, 3'b001, 32'h21, 32'h0000FFFF, 32'h0, 1, "sh_mis_21");
        xfer(0, 3'b010, 32'h22, 0, 32'h0, 1, "lw_mis_22");
        xfer(0, 3'b011, 32'h10, 0, 32'h0, 1, "width_011");
        xfer(0, 3'b111, 32'h10, 0, 32'h0, 1, "width_111");
        xfer(1, 3'b100, 32'h10, 32'h000000FF, 32'h0, 1, "sb_w100");
        xfer(1, 3'b101, 32'h20, 32'h0000FFFF, 32'h0, 1, "sh_w101");
        xfer(0, 3'b010, 32'h20, 0, 32'h80010000, 0, "lw_20_after_err");
        xfer(0, 3'b010, 32'h10, 0, 32'hAB223344, 0, "lw_10_after_err");

        // range and back-to-back
        xfer(0, 3'b010, 32'h100, 0, 32'h0, 1, "lw_range_100");
        xfer(1, 3'b010, 32'h100, 32'h12345678, 32'h0, 1, "sw_range_100");
        xfer(1, 3'b010, 32'h4, 32'hDEADBEEF, 32'h0, 0, "sw_4_b2b");
        xfer(0, 3'b010, 32'h4, 0, 32'hDEADBEEF, 0, "lw_4_b2b");
        xfer(0, 3'b010, 32'h0, 0, 32'h00000000, 0, "lw_0_untouched");
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got v=%b d=%h e=%b expected 0/00000000/0",
                     rsp_valid, rsp_rdata, rsp_error);
        end

        // reset mid-clear
        reset = 1'b1;
        release_reset();
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL midclear_ready: got %b expected 0", req_ready);
        end
        release_reset();
        wait_ready("clear_restart");

        // reset one cycle after an accepted store
        xfer(1, 3'b010, 32'h8, 32'hCAFEF00D, 32'h0, 0, "sw_8_pre_reset");
        reset = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_drops_valid: got %b expected 0", rsp_valid);
        end
        release_reset();
        wait_ready("clear_after_sw");
        xfer(0, 3'b010, 32'h8, 0, 32'h00000000, 0, "lw_8_cleared");
        xfer(0, 3'b010, 32'h10, 0, 32'h00000000, 0, "lw_10_cleared");
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
